hex_ascii_streamer: RTL

Converts a DATA_WIDTH-bit binary word into a serial stream of ASCII hex characters, one byte per handshake. Output is MSB nibble first, with an optional "0x" prefix, optional leading-zero suppression, upper/lower case selection and an optional line terminator. It sits between sensor/status registers and the UART transmitter for human-readable debug and telemetry output.

---
 rtl/hex_ascii_streamer.sv | 94 +++++++++
 1 files changed

// File: rtl/hex_ascii_streamer.sv
// hex_ascii_streamer: formats a binary word as an ASCII hex character stream, one byte per handshake.
module hex_ascii_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int PREFIX_EN  = 1,
  parameter int TERM_MODE  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  lowercase,
  input  logic                  suppress_zeros,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic                  out_last,
  output logic                  busy
);
  localparam int NDIG = (DATA_WIDTH + 3) / 4;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGITS, TERM_CR, TERM_LF} state_t;
  localparam state_t FIRST = PREFIX_EN != 0 ? PFX0 : DIGITS;
  localparam state_t AFTER = TERM_MODE == 2 ? TERM_CR : TERM_MODE == 1 ? TERM_LF : IDLE;
  state_t state, nstate;
  logic [NDIG*4-1:0] data, ndata, wd;
  logic [IW-1:0] idx, nidx, msn;
  logic lc, nlc, nvalid, nbusy, nready, nlast;
  logic [7:0] nchar;
  function automatic logic [7:0] char_of(state_t s, logic [IW-1:0] i, logic [NDIG*4-1:0] d, logic l);
    logic [3:0] n;
    n = d[i*4 +: 4];
    return s == PFX0 ? 8'h30 : s == PFX1 ? 8'h78 : s == TERM_CR ? 8'h0d : s == TERM_LF ? 8'h0a :
           s == DIGITS ? (n < 4'd10 ? 8'h30 + 8'(n) : (l ? 8'h57 : 8'h37) + 8'(n)) : 8'h00;
  endfunction
  always_comb begin
    nstate = state;
    nidx = idx;
    ndata = data;
    nlc = lc;
    nvalid = out_valid;
    nbusy = busy;
    nready = in_ready;
    wd = '0;
    wd[DATA_WIDTH-1:0] = in_data;
    msn = '0;
    for (int i = 0; i < NDIG; i++) msn = wd[i*4 +: 4] != 4'd0 ? IW'(i) : msn;
    if (state == IDLE) begin
      nready = 1'b1;
      if (in_valid && in_ready) begin
        nstate = FIRST;
        ndata = wd;
        nlc = lowercase;
        nidx = suppress_zeros ? msn : IW'(NDIG - 1);
        nvalid = 1'b1;
        nbusy = 1'b1;
        nready = 1'b0;
      end
    end else if (out_valid && out_ready) begin
      nstate = state == PFX0 ? PFX1 : state == PFX1 ? DIGITS : state == TERM_CR ? TERM_LF :
               state == DIGITS ? (idx == '0 ? AFTER : DIGITS) : IDLE;
      nidx = state == DIGITS && idx != '0 ? idx - 1'b1 : idx;
      nvalid = nstate != IDLE;
      nbusy = nstate != IDLE;
      nready = nstate == IDLE;
    end
    // Outputs are precomputed from the next state so they can be registered with no extra latency.
    nchar = char_of(nstate, nidx, ndata, nlc);
    nlast = nstate == TERM_LF || (nstate == DIGITS && nidx == '0 && TERM_MODE == 0);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      data <= '0;
      idx <= '0;
      lc <= 1'b0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_char <= 8'h00;
      out_last <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nstate;
      data <= ndata;
      idx <= nidx;
      lc <= nlc;
      in_ready <= nready;
      out_valid <= nvalid;
      out_char <= nchar;
      out_last <= nlast;
      busy <= nbusy;
    end
  end
endmodule
